register_file: RTL and testbench
================================

Name: register_file

Overview:
- 16-entry x 24-bit general-purpose register file for the 24-bit CPU datapath.
- Two asynchronous (combinational) read ports, RS and RT; one synchronous write port, RD.
- Sits between instruction decode, which supplies the register indices, and the ALU/writeback stage, which supplies WriteData and RegWrite.

Parameters:
- DATA_W, 24, width of each register and of the data ports.
- ADDR_W, 4, width of the register index.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_W.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- RS  input  ADDR_W  read port A register index.
- RT  input  ADDR_W  read port B register index.
- RD  input  ADDR_W  write register index.
- WriteData  input  DATA_W  data to be written.
- RegWrite  input  1  write enable.
- ReadRS  output  DATA_W  contents of register RS.
- ReadRT  output  DATA_W  contents of register RT.

Behaviour:
- Reset: at a rising Clock edge with Reset=1, all 16 registers become 0. Reset has priority over a simultaneous write.
- Write: at a rising Clock edge with Reset=0 and RegWrite=1, register[RD] takes WriteData. With RegWrite=0, no register changes.
- Register 0 is hardwired to zero:
  - writes to RD=0 are ignored;
  - ReadRS and ReadRT return 0 whenever the index is 0.
- Reads are purely combinational. ReadRS = register[RS] and ReadRT = register[RT]. There is no clock latency; outputs track changes in the index in the same delta cycle.
- Write latency: new data appears on a read port after the write edge, not before (unless REGFILE_BYPASS_EN is defined).
- RS and RT may be equal; both ports then return the same value.
- Reading the register being written in the same cycle returns the old value until the edge (without bypass).
- Unknown (X) indices: outputs are don't-care. No assertion is required, but simulation must not crash.
- Output values after reset and before any write are 0 for all indices.
- Write to RD while Reset=1: ignored.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When RegWrite=1, RD!=0 and RS==RD, ReadRS = WriteData combinationally. The same rule applies to RT/ReadRT. Forwarding is suppressed while Reset=1.
- Not defined: reads return stored contents only, as described above.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W=24, ADDR_W=4, NUM_REGS=16;
  - typedef reg_idx_t (logic [ADDR_W-1:0]);
  - typedef reg_data_t (logic [DATA_W-1:0]);
  - constant ZERO_REG=0.
- One sub-module, regfile_read_port. It is instantiated twice, once for RS and once for RT. It holds the index-to-data mux, the zero-register forcing, and the optional bypass compare.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset: assert Reset for one edge, then read RS=0..15 -> all ReadRS/ReadRT = 0.
- Write/read: RD=8, WriteData=4, RegWrite=1, one edge; then RD=9, WriteData=2, one edge; RegWrite=0; RS=8, RT=9 -> ReadRS=4, ReadRT=2.
- Write-enable low: RegWrite=0, RD=8, WriteData=0xABCDEF, edge -> ReadRS (RS=8) stays 4.
- Register zero: RegWrite=1, RD=0, WriteData=0x123456, edge; RS=0 -> ReadRS=0.
- Reset priority: Reset=1 and RegWrite=1 with RD=5, WriteData=7 on the same edge -> register 5 = 0. After that, write 7 to RD=5 and read RS=RT=5 -> both ports = 7.
- Bypass (REGFILE_BYPASS_EN defined): RegWrite=1, RD=3, WriteData=0x00FF00, RS=3 before the edge -> ReadRS=0x00FF00 immediately. Without the macro -> old value (0) until the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the 16x24 CPU register file.
// REGFILE_BYPASS_EN (in register_file / regfile_read_port) adds write-through forwarding.
package regfile_pkg;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, r0 forced to zero, optional forwarding.
// Zero latency, no backpressure; REGFILE_BYPASS_EN forwards an in-flight write to the same index.
module regfile_read_port
    import regfile_pkg::*;
(
    input  reg_data_t regs [NUM_REGS],
    input  reg_idx_t  idx,
`ifdef REGFILE_BYPASS_EN
    input  logic      rst,
    input  logic      wr_en,
    input  reg_idx_t  wr_idx,
    input  reg_data_t wr_data,
`endif
    output reg_data_t data
);

    always_comb begin
        data = regs[idx];
`ifdef REGFILE_BYPASS_EN
        // Forwarding never applies to r0 and is held off while reset clears the array.
        if (!rst && wr_en && (wr_idx != ZERO_REG) && (wr_idx == idx)) begin
            data = wr_data;
        end
`endif
        if (idx == ZERO_REG) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// register_file: 16x24 GPR file, two combinational read ports, one write port (1 edge).
// No backpressure; define REGFILE_BYPASS_EN for write-through forwarding to the read ports.
module register_file
    import regfile_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT
);

    reg_data_t regs [NUM_REGS];

    // Reset wins over a same-edge write; r0 is never written so it stays zero.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (RD != ZERO_REG)) begin
            regs[RD] <= WriteData;
        end
    end

    regfile_read_port u_port_rs (
        .regs    (regs),
        .idx     (RS),
`ifdef REGFILE_BYPASS_EN
        .rst     (Reset),
        .wr_en   (RegWrite),
        .wr_idx  (RD),
        .wr_data (WriteData),
`endif
        .data    (ReadRS)
    );

    regfile_read_port u_port_rt (
        .regs    (regs),
        .idx     (RT),
`ifdef REGFILE_BYPASS_EN
        .rst     (Reset),
        .wr_en   (RegWrite),
        .wr_idx  (RD),
        .wr_data (WriteData),
`endif
        .data    (ReadRT)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file;

    logic        Clock;
    logic        Reset;
    logic [3:0]  RS;
    logic [3:0]  RT;
    logic [3:0]  RD;
    logic [23:0] WriteData;
    logic        RegWrite;
    logic [23:0] ReadRS;
    logic [23:0] ReadRT;

    int n_checks;
    int n_pass;

    register_file dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well clear of it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [23:0] pattern(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'hF0, 8'(i * 3)};
    endfunction

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Reset     = 1'b1;
        RegWrite  = 1'b0;
        RS        = '0;
        RT        = '0;
        RD        = '0;
        WriteData = '0;

        tick();
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            RS = 4'(i);
            RT = 4'(15 - i);
            #1;
            check($sformatf("reset_rs%0d", i), ReadRS, 24'h0);
            check($sformatf("reset_rt%0d", 15 - i), ReadRT, 24'h0);
        end

        RegWrite = 1'b1; RD = 4'd8; WriteData = 24'd4;
        tick();
        RD = 4'd9; WriteData = 24'd2;
        tick();
        RegWrite = 1'b0; RS = 4'd8; RT = 4'd9;
        #1;
        check("wr_r8", ReadRS, 24'd4);
        check("wr_r9", ReadRT, 24'd2);

        RD = 4'd8; WriteData = 24'hABCDEF;
        tick();
        RS = 4'd8;
        #1;
        check("we_low_r8", ReadRS, 24'd4);

        RegWrite = 1'b1; RD = 4'd0; WriteData = 24'h123456;
        tick();
        RegWrite = 1'b0; RS = 4'd0; RT = 4'd0;
        #1;
        check("r0_rs", ReadRS, 24'h0);
        check("r0_rt", ReadRT, 24'h0);

        RegWrite = 1'b1; RD = 4'd5; WriteData = 24'h111111;
        tick();
        RegWrite = 1'b0; RS = 4'd5;
        #1;
        check("preload_r5", ReadRS, 24'h111111);

        Reset = 1'b1; RegWrite = 1'b1; RD = 4'd5; WriteData = 24'd7;
        tick();
        Reset = 1'b0; RegWrite = 1'b0; RS = 4'd5; RT = 4'd8;
        #1;
        check("rst_prio_r5", ReadRS, 24'h0);
        check("rst_clears_r8", ReadRT, 24'h0);

        RegWrite = 1'b1; RD = 4'd5; WriteData = 24'd7;
        tick();
        RegWrite = 1'b0; RS = 4'd5; RT = 4'd5;
        #1;
        check("same_idx_rs", ReadRS, 24'd7);
        check("same_idx_rt", ReadRT, 24'd7);

        RegWrite = 1'b1; RD = 4'd3; WriteData = 24'h00FF00; RS = 4'd3; RT = 4'd2;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pre_edge_rs3", ReadRS, 24'h00FF00);
`else
        check("pre_edge_rs3", ReadRS, 24'h0);
`endif
        check("pre_edge_rt2", ReadRT, 24'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("post_edge_rs3", ReadRS, 24'h00FF00);

        Reset = 1'b1; RegWrite = 1'b1; RD = 4'd4; WriteData = 24'h000ABC; RS = 4'd4;
        #1;
        check("rst_no_fwd_rs4", ReadRS, 24'h0);
        tick();
        Reset = 1'b0; RegWrite = 1'b0;
        #1;
        check("rst_drop_rs4", ReadRS, 24'h0);

        RegWrite = 1'b1;
        for (int i = 1; i < 16; i++) begin
            RD = 4'(i);
            WriteData = pattern(i);
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 1; i < 16; i++) begin
            RS = 4'(i);
            RT = 4'((i % 15) + 1);
            #1;
            check($sformatf("fill_rs%0d", i), ReadRS, pattern(i));
            check($sformatf("fill_rt%0d", (i % 15) + 1), ReadRT, pattern((i % 15) + 1));
        end
        RS = 4'd0;
        #1;
        check("fill_r0", ReadRS, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
